// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, data-first with fetch starvation guard
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_D_STREAK  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    resp_state_t         state;
    logic [STREAK_W-1:0] streak;
    logic                fetch_due;

    // A waiting fetch that has watched MAX_D_STREAK data grants goes next.
    assign fetch_due = if_req && (streak == STREAK_MAX);

    always_comb begin
        if_gnt    = !rst && if_req && (!d_req || fetch_due);
        d_gnt     = !rst && d_req && !fetch_due;
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = if_gnt ? if_addr : d_addr;
        mem_wdata = d_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            if (if_gnt)
                state <= RESP_I;
            else if (d_gnt && !d_we)
                state <= RESP_D;
            else
                state <= IDLE;

            if (!if_req || if_gnt)
                streak <= '0;
            else if (d_gnt && (streak != STREAK_MAX))
                streak <= streak + 1'b1;
        end
    end

    // Gating with rst drops a response whose grant landed just before reset.
    assign if_rvalid = (state == RESP_I) && !rst;
    assign d_rvalid  = (state == RESP_D) && !rst;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 32, the width of all address ports.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, the width of all data ports.
REQ-003 The module SHALL have parameter MAX_D_STREAK, default 4, the number of consecutive data grants allowed while a fetch waits.
REQ-004 The module SHALL have these ports (name, direction, width, meaning):
 - clk, in, 1: single clock; all state updates on its rising edge.
 - rst, in, 1: synchronous, active-high reset.
 - if_req, in, 1: fetch read request.
 - if_addr, in, ADDRESS_WIDTH: fetch address.
 - if_gnt, out, 1: fetch request accepted this cycle.
 - if_rvalid, out, 1: if_rdata valid.
 - if_rdata, out, DATA_WIDTH: fetch read data.
 - d_req, in, 1: data request.
 - d_we, in, 1: data write (1) or read (0).
 - d_addr, in, ADDRESS_WIDTH: data address.
 - d_wdata, in, DATA_WIDTH: write data.
 - d_gnt, out, 1: data request accepted this cycle.
 - d_rvalid, out, 1: d_rdata valid (reads only).
 - d_rdata, out, DATA_WIDTH: data read data.
 - mem_en, out, 1: memory access strobe.
 - mem_we, out, 1: memory write enable.
 - mem_addr, out, ADDRESS_WIDTH: memory address.
 - mem_wdata, out, DATA_WIDTH: memory write data.
 - mem_rdata, in, DATA_WIDTH: memory read data, valid one cycle after an mem_en read.

Function
REQ-005 Grants SHALL be combinational in the request cycle; at most one of if_gnt, d_gnt SHALL be high per cycle.
REQ-006 A requester SHALL hold req, addr, we and wdata stable until its gnt; the arbiter SHALL accept no request without a grant.
REQ-007 On any grant, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL carry the granted requester's signals, with mem_we 0 for fetch; with no grant, mem_en and mem_we SHALL be 0.
REQ-008 Priority: data SHALL win over fetch, except that fetch SHALL win when if_req is high and streak == MAX_D_STREAK.
REQ-009 streak (width clog2(MAX_D_STREAK+1)) SHALL increment on a d_gnt while if_req is high, saturate at MAX_D_STREAK, and clear on an if_gnt or on any cycle with if_req low.
REQ-010 Response FSM states: IDLE, RESP_I, RESP_D; the next state SHALL be RESP_I after an if_gnt, RESP_D after a d_gnt with d_we=0, and IDLE otherwise (including after a write grant).
REQ-011 In RESP_I, if_rvalid SHALL be 1 and if_rdata = mem_rdata; in RESP_D, d_rvalid SHALL be 1 and d_rdata = mem_rdata; otherwise both rvalids SHALL be 0.
REQ-012 Read latency SHALL be exactly one cycle from gnt to rvalid; a new grant in a RESP state SHALL be allowed, giving one access per cycle.
REQ-013 Writes SHALL complete in the grant cycle and produce no rvalid.
REQ-014 When if_rvalid or d_rvalid is 0, the corresponding rdata SHALL be driven to 0.

Reset
REQ-015 When rst is high at a clock edge, state SHALL become IDLE and streak 0.
REQ-016 While rst is high, if_gnt, d_gnt, mem_en and mem_we SHALL be 0; a read granted in the cycle before reset SHALL not produce rvalid after reset.

Structure
REQ-017 The state enum (IDLE, RESP_I, RESP_D) SHALL be defined in shared package mem_arb_pkg.
REQ-018 The module SHALL be a single module with no sub-module; the streak counter and FSM SHALL be inline.

Verification
REQ-019 Fetch only: if_req=1, if_addr=0x10 -> if_gnt=1, mem_en=1, mem_addr=0x10 same cycle; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-020 Both requesting (d_we=0, d_addr=0x200; if_addr=0x40) -> d_gnt=1, if_gnt=0, mem_addr=0x200; next cycle d_rvalid=1.
REQ-021 Starvation guard: d_req and if_req held high for 6 cycles -> d_gnt in cycles 1-4, if_gnt in cycle 5, d_gnt in cycle 6.
REQ-022 Write: d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF -> mem_we=1 with those values; next cycle d_rvalid=0, state IDLE.
REQ-023 Back-to-back: fetch 0x0 then fetch 0x4 on consecutive cycles -> if_rvalid high two consecutive cycles, in order.
REQ-024 Reset mid-op: fetch granted, rst=1 next cycle -> if_rvalid=0, if_gnt=0, mem_en=0; after rst low, streak 0 and fetch granted normally.
